// File: rtl/loader_pkg.sv
// loader_pkg: shared FSM state encoding and header width for the instruction loader.
//   HDR_W   - width of the little-endian word-count header
//   state_t - loader FSM states
package loader_pkg;
    localparam int unsigned HDR_W = 16;
    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        DONE,
        ERROR
    } state_t;
endpackage

// File: rtl/word_assembler.sv
// word_assembler: packs little-endian bytes into a 32-bit word.
//   clk, reset - clock and asynchronous active-high reset
//   clear      - zero the assembled word
//   byte_en    - write byte_in into lane idx
//   byte_in    - incoming byte
//   idx        - 2-bit byte lane, lane k occupies bits [8k+7:8k]
//   word_out   - assembled word
module word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    input  logic [1:0]  idx,
    output logic [31:0] word_out
);
    logic [31:0] word_q, word_d;
    always_comb begin
        word_d = word_q;
        for (int i = 0; i < 4; i++)
            if (byte_en && idx == 2'(i)) word_d[8*i +: 8] = byte_in;
        if (clear) word_d = '0;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) word_q <= '0;
        else       word_q <= word_d;
    end
    assign word_out = word_q;
endmodule

// File: rtl/instr_loader.sv
// instr_loader: loads a length-prefixed byte stream into instruction memory.
//   clk, reset      - clock and asynchronous active-high reset
//   in_valid/in_data/in_ready - byte stream handshake
//   restart         - reload request, honoured only when done
//   mem_write_*     - instruction memory write port (one word per WRITE cycle)
//   cpu_reset       - core held in reset until the program is fully written
//   done / error    - load complete / header length exceeded MAX_WORDS (sticky)
module instr_loader
    import loader_pkg::*;
#(
    parameter int unsigned  MAX_WORDS = 256,
    parameter logic [31:0]  BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic        restart,
    output logic        mem_write_en,
    output logic [31:0] mem_write_addr,
    output logic [31:0] mem_write_data,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);
    state_t           state_q, state_d;
    logic [HDR_W-1:0] count_q, count_d;
    logic [HDR_W-1:0] word_idx_q, word_idx_d;
    logic [1:0]       k_q, k_d;
    logic             accept;
    logic             asm_clear;
    logic [HDR_W-1:0] hdr_n;
    logic [HDR_W-1:0] idx_inc;
    logic [31:0]      word;

    assign in_ready       = state_q == LEN_LO || state_q == LEN_HI || state_q == DATA;
    assign accept         = in_valid && in_ready;
    assign asm_clear      = state_q == DONE && restart;
    // Full header as it will be once the high byte in flight is latched.
    assign hdr_n          = {in_data, count_q[7:0]};
    assign idx_inc        = word_idx_q + 16'd1;
    assign mem_write_en   = state_q == WRITE;
    assign mem_write_addr = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
    assign mem_write_data = word;
    assign cpu_reset      = state_q != DONE;
    assign done           = state_q == DONE;
    assign error          = state_q == ERROR;

    word_assembler u_asm (
        .clk      (clk),
        .reset    (reset),
        .clear    (asm_clear),
        .byte_en  (accept && state_q == DATA),
        .byte_in  (in_data),
        .idx      (k_q),
        .word_out (word)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        k_d        = k_q;
        case (state_q)
            LEN_LO: if (accept) begin
                count_d[7:0] = in_data;
                state_d      = LEN_HI;
            end
            LEN_HI: if (accept) begin
                count_d[15:8] = in_data;
                state_d = hdr_n == '0 ? DONE :
                          {16'd0, hdr_n} > MAX_WORDS ? ERROR : DATA;
            end
            // k wraps to 0 on the fourth byte, ready for the next word.
            DATA: if (accept) begin
                k_d = k_q + 2'd1;
                if (k_q == 2'd3) state_d = WRITE;
            end
            WRITE: begin
                word_idx_d = idx_inc;
                state_d    = idx_inc == count_q ? DONE : DATA;
            end
            DONE: if (restart) begin
                count_d    = '0;
                word_idx_d = '0;
                k_d        = '0;
                state_d    = LEN_LO;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= LEN_LO;
            count_q    <= '0;
            word_idx_q <= '0;
            k_q        <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            k_q        <= k_d;
        end
    end
endmodule
